// File: rtl/sram_access_sequencer.sv
//------------------------------------------------------------------------------
// sram_access_sequencer
//
// Front-end controller for the 2R/1W wordline decoder of the SRAM macro.
// Accepts one request per handshake (up to two reads plus one write). It then
// sequences the precharge, wordline/sense and write phases, captures the
// sensed read data, and returns one response pulse per non-null request.
//
// Ports
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   i_req_valid/o_req_ready  request handshake; ready is high only in IDLE
//   i_req_rd_en[1:0]         [1] = read port 1 (raddr1), [0] = read port 2
//   i_req_we                 write request
//   i_req_raddr1/2, i_req_waddr, i_req_wdata   request fields
//   o_address_1              decoder address 1 (read port 1 and write port)
//   o_address_2              decoder address 2 (read port 2)
//   o_read_enable[1:0]       decoder read enables, same mapping as rd_en
//   o_write_enable           decoder write enable
//   o_precharge_n            bitline precharge, active low
//   o_sense_en               sense-amp enable
//   o_bl_wdata               write bitline data
//   i_bl_rdata1/2            sensed bitline data for read port 1/2
//   o_rsp_valid              one-cycle response pulse, no backpressure
//   o_rsp_rdata1/2           response read data, 0 for ports not enabled
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module sram_access_sequencer #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int PRE_CYC = 1,
  parameter int WL_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [1:0]        i_req_rd_en,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_raddr1,
  input  logic [ADDR_W-1:0] i_req_raddr2,
  input  logic [ADDR_W-1:0] i_req_waddr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic [ADDR_W-1:0] o_address_1,
  output logic [ADDR_W-1:0] o_address_2,
  output logic [1:0]        o_read_enable,
  output logic              o_write_enable,
  output logic              o_precharge_n,
  output logic              o_sense_en,
  output logic [DATA_W-1:0] o_bl_wdata,
  input  logic [DATA_W-1:0] i_bl_rdata1,
  input  logic [DATA_W-1:0] i_bl_rdata2,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata1,
  output logic [DATA_W-1:0] o_rsp_rdata2
);

  localparam int MAX_CYC = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] WL_LAST  = CNT_W'(WL_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_READ,
    S_PRE_W,
    S_WRITE,
    S_RESP
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;

  // Latched request
  logic [1:0]         r_rd_en;
  logic               r_we;
  logic [ADDR_W-1:0]  r_raddr1;
  logic [ADDR_W-1:0]  r_raddr2;
  logic [ADDR_W-1:0]  r_waddr;
  logic [DATA_W-1:0]  r_wdata;

  // Registered outputs
  logic               r_req_ready;
  logic [ADDR_W-1:0]  r_address_1;
  logic [ADDR_W-1:0]  r_address_2;
  logic [1:0]         r_read_enable;
  logic               r_write_enable;
  logic               r_precharge_n;
  logic               r_sense_en;
  logic [DATA_W-1:0]  r_bl_wdata;
  logic               r_rsp_valid;

  state_t             w_state_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_accept;
  logic               w_capture;
  logic               w_enter_resp;
  logic [DATA_W-1:0]  w_bl_rdata [2];

  assign w_accept     = i_req_valid & r_req_ready;
  // Sensed data is valid at the end of the last wordline cycle of READ.
  assign w_capture    = (r_state == S_READ) && (r_cnt == WL_LAST);
  assign w_enter_resp = (w_state_next == S_RESP);

  // Index matches the rd_en bit of each read port.
  assign w_bl_rdata[1] = i_bl_rdata1;
  assign w_bl_rdata[0] = i_bl_rdata2;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        // Null requests are accepted but never leave IDLE.
        if (w_accept && ((i_req_rd_en != 2'b00) || i_req_we))
          w_state_next = S_PRE;
      end
      S_PRE: begin
        if (r_cnt == PRE_LAST) begin
          w_cnt_next   = '0;
          w_state_next = (r_rd_en != 2'b00) ? S_READ : S_WRITE;
        end
      end
      S_READ: begin
        if (r_cnt == WL_LAST) begin
          w_cnt_next   = '0;
          w_state_next = r_we ? S_PRE_W : S_RESP;
        end
      end
      S_PRE_W: begin
        if (r_cnt == PRE_LAST) begin
          w_cnt_next   = '0;
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (r_cnt == WL_LAST) begin
          w_cnt_next   = '0;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_cnt_next   = '0;
        w_state_next = S_IDLE;
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state, so each phase's drive values
  // appear exactly in the cycles the FSM spends in that phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_rd_en        <= '0;
      r_we           <= 1'b0;
      r_raddr1       <= '0;
      r_raddr2       <= '0;
      r_waddr        <= '0;
      r_wdata        <= '0;
      r_req_ready    <= 1'b1;
      r_address_1    <= '0;
      r_address_2    <= '0;
      r_read_enable  <= '0;
      r_write_enable <= 1'b0;
      r_precharge_n  <= 1'b1;
      r_sense_en     <= 1'b0;
      r_bl_wdata     <= '0;
      r_rsp_valid    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;

      if (w_accept) begin
        r_rd_en  <= i_req_rd_en;
        r_we     <= i_req_we;
        r_raddr1 <= i_req_raddr1;
        r_raddr2 <= i_req_raddr2;
        r_waddr  <= i_req_waddr;
        r_wdata  <= i_req_wdata;
      end

      r_req_ready    <= (w_state_next == S_IDLE);
      r_precharge_n  <= !((w_state_next == S_PRE) || (w_state_next == S_PRE_W));
      r_read_enable  <= (w_state_next == S_READ) ? r_rd_en : 2'b00;
      r_write_enable <= (w_state_next == S_WRITE);
      r_sense_en     <= (w_state_next == S_READ) && (w_cnt_next == WL_LAST);
      r_bl_wdata     <= (w_state_next == S_WRITE) ? r_wdata : '0;
      r_rsp_valid    <= w_enter_resp;

      // address_1 is shared by read port 1 and the write port.
      if (w_state_next == S_READ)
        r_address_1 <= r_raddr1;
      else if (w_state_next == S_WRITE)
        r_address_1 <= r_waddr;
      else
        r_address_1 <= '0;
      r_address_2 <= (w_state_next == S_READ) ? r_raddr2 : '0;
    end
  end

  // Per read port: capture sensed data, then publish it on RESP entry.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [DATA_W-1:0] r_cap;
    logic [DATA_W-1:0] r_rsp_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cap       <= '0;
        r_rsp_rdata <= '0;
      end else begin
        if (w_capture)
          r_cap <= w_bl_rdata[gi];
        // Read-only requests enter RESP on the capture edge itself, so the
        // live bitline data must bypass the capture register then.
        if (w_enter_resp) begin
          if (!r_rd_en[gi])
            r_rsp_rdata <= '0;
          else if (w_capture)
            r_rsp_rdata <= w_bl_rdata[gi];
          else
            r_rsp_rdata <= r_cap;
        end
      end
    end
  end

  assign o_req_ready    = r_req_ready;
  assign o_address_1    = r_address_1;
  assign o_address_2    = r_address_2;
  assign o_read_enable  = r_read_enable;
  assign o_write_enable = r_write_enable;
  assign o_precharge_n  = r_precharge_n;
  assign o_sense_en     = r_sense_en;
  assign o_bl_wdata     = r_bl_wdata;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_rdata1   = g_port[1].r_rsp_rdata;
  assign o_rsp_rdata2   = g_port[0].r_rsp_rdata;

endmodule

// File: tb/tb_sram_access_sequencer.sv
`timescale 1ns/1ps
module tb_sram_access_sequencer;

  localparam int AW  = 7;
  localparam int DW  = 32;
  localparam int PRE = 1;
  localparam int WL  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req_valid;
  logic          o_req_ready;
  logic [1:0]    i_req_rd_en;
  logic          i_req_we;
  logic [AW-1:0] i_req_raddr1, i_req_raddr2, i_req_waddr;
  logic [DW-1:0] i_req_wdata;
  logic [AW-1:0] o_address_1, o_address_2;
  logic [1:0]    o_read_enable;
  logic          o_write_enable, o_precharge_n, o_sense_en, o_rsp_valid;
  logic [DW-1:0] o_bl_wdata, i_bl_rdata1, i_bl_rdata2, o_rsp_rdata1, o_rsp_rdata2;

  always #5 clk = ~clk;

  sram_access_sequencer #(.ADDR_W(AW), .DATA_W(DW), .PRE_CYC(PRE), .WL_CYC(WL)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_rd_en(i_req_rd_en), .i_req_we(i_req_we),
    .i_req_raddr1(i_req_raddr1), .i_req_raddr2(i_req_raddr2),
    .i_req_waddr(i_req_waddr), .i_req_wdata(i_req_wdata),
    .o_address_1(o_address_1), .o_address_2(o_address_2),
    .o_read_enable(o_read_enable), .o_write_enable(o_write_enable),
    .o_precharge_n(o_precharge_n), .o_sense_en(o_sense_en),
    .o_bl_wdata(o_bl_wdata), .i_bl_rdata1(i_bl_rdata1), .i_bl_rdata2(i_bl_rdata2),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata1(o_rsp_rdata1), .o_rsp_rdata2(o_rsp_rdata2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SRAM array emulation ----------------
  function automatic logic [31:0] init_val(input logic [6:0] a);
    case (a)
      7'h3C:   init_val = 32'hA5A5_0001;
      7'h4F:   init_val = 32'h5A5A_0002;
      default: init_val = {a, 25'h0} ^ 32'h0F1E_2D3C ^ {25'h0, a};
    endcase
  endfunction

  bit [31:0]  sram [128];
  bit [127:0] written;

  always @(posedge clk) begin
    if (o_write_enable) begin
      sram[o_address_1]    <= o_bl_wdata;
      written[o_address_1] <= 1'b1;
    end
  end

  function automatic logic [31:0] arr_rd(input logic [6:0] a);
    arr_rd = written[a] ? sram[a] : init_val(a);
  endfunction

  // Undriven bitlines carry changing junk so ungated capture is visible.
  always_comb begin
    i_bl_rdata1 = o_read_enable[1] ? arr_rd(o_address_1) : {16'hBAD1, cyc[15:0]};
    i_bl_rdata2 = o_read_enable[0] ? arr_rd(o_address_2) : {16'hBAD2, cyc[15:0]};
  end

  // ---------------- Behavioural model ----------------
  typedef struct {
    bit        ready, pn, we, se, rv, a1c, a2c, commit;
    bit [1:0]  re;
    bit [6:0]  a1, a2, cwa;
    bit [31:0] wd, r1, r2, cwd;
  } vec_t;

  vec_t      q[$];
  vec_t      cur;
  bit [31:0] hold1, hold2;
  bit [31:0] model_mem [128];

  function automatic vec_t base_vec(input bit rdy);
    vec_t v;
    v = '{default: 0};
    v.ready = rdy;
    v.pn    = 1'b1;
    v.a1c   = 1'b1;
    v.a2c   = 1'b1;
    return v;
  endfunction

  // Each accepted request expands into its cycle-by-cycle output schedule.
  initial begin
    vec_t v;
    for (int i = 0; i < 128; i++) model_mem[i] = init_val(7'(i));
    cur = base_vec(1'b1);
    hold1 = 0;
    hold2 = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        cur = base_vec(1'b1);
        hold1 = 0;
        hold2 = 0;
      end else begin
        if (cur.ready && i_req_valid === 1'b1) begin
          if (i_req_rd_en == 2'b00 && !i_req_we) begin
            $display("txn null request accepted at cycle %0d", cyc);
          end else begin
            for (int k = 0; k < PRE; k++) begin
              v = base_vec(0); v.pn = 0; q.push_back(v);
            end
            if (i_req_rd_en != 2'b00) begin
              for (int k = 0; k < WL; k++) begin
                v = base_vec(0);
                v.re = i_req_rd_en;
                v.a1 = i_req_raddr1; v.a1c = i_req_rd_en[1];
                v.a2 = i_req_raddr2; v.a2c = i_req_rd_en[0];
                v.se = (k == WL - 1);
                q.push_back(v);
              end
              if (i_req_we)
                for (int k = 0; k < PRE; k++) begin
                  v = base_vec(0); v.pn = 0; q.push_back(v);
                end
            end
            if (i_req_we)
              for (int k = 0; k < WL; k++) begin
                v = base_vec(0);
                v.we = 1; v.a1 = i_req_waddr; v.wd = i_req_wdata;
                q.push_back(v);
              end
            v = base_vec(0);
            v.rv = 1;
            v.r1 = i_req_rd_en[1] ? model_mem[i_req_raddr1] : 32'h0;
            v.r2 = i_req_rd_en[0] ? model_mem[i_req_raddr2] : 32'h0;
            v.commit = i_req_we; v.cwa = i_req_waddr; v.cwd = i_req_wdata;
            q.push_back(v);
            $display("txn rd_en=%b we=%b ra1=%h ra2=%h wa=%h wd=%h exp_r1=%h exp_r2=%h lat=%0d",
                     i_req_rd_en, i_req_we, i_req_raddr1, i_req_raddr2, i_req_waddr,
                     i_req_wdata, v.r1, v.r2, q.size());
          end
        end
        if (q.size() > 0) cur = q.pop_front();
        else              cur = base_vec(1'b1);
        if (cur.rv) begin
          hold1 = cur.r1;
          hold2 = cur.r2;
          if (cur.commit) model_mem[cur.cwa] = cur.cwd;
        end
      end
    end
  end

  // ---------------- Per-cycle compare ----------------
  initial begin
    bit ok;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        ok = (o_req_ready === cur.ready) && (o_precharge_n === cur.pn) &&
             (o_read_enable === cur.re) && (o_write_enable === cur.we) &&
             (o_sense_en === cur.se) && (!cur.a1c || o_address_1 === cur.a1) &&
             (!cur.a2c || o_address_2 === cur.a2) && (o_bl_wdata === cur.wd) &&
             (o_rsp_valid === cur.rv) && (o_rsp_rdata1 === hold1) &&
             (o_rsp_rdata2 === hold2);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL cycle_outputs cyc=%0d got rdy=%b pn=%b re=%b we=%b se=%b a1=%h a2=%h wd=%h rv=%b r1=%h r2=%h exp rdy=%b pn=%b re=%b we=%b se=%b a1=%h a2=%h wd=%h rv=%b r1=%h r2=%h",
                   cyc, o_req_ready, o_precharge_n, o_read_enable, o_write_enable, o_sense_en,
                   o_address_1, o_address_2, o_bl_wdata, o_rsp_valid, o_rsp_rdata1, o_rsp_rdata2,
                   cur.ready, cur.pn, cur.re, cur.we, cur.se, cur.a1, cur.a2, cur.wd, cur.rv,
                   hold1, hold2);
        end
        if (o_rsp_valid === 1'b1) rsp_cnt++;
      end
    end
  end

  // ---------------- Helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [31:0] ob_re [1:8], ob_we [1:8], ob_se [1:8], ob_pn [1:8];
  logic [31:0] ob_rv [1:8], ob_a1 [1:8], ob_rd1 [1:8], ob_rd2 [1:8];

  // Records cycles 1..n after the accept edge (called at cycle 1's negedge).
  task automatic observe(input int n);
    for (int k = 1; k <= n; k++) begin
      ob_re[k]  = 32'(o_read_enable);
      ob_we[k]  = 32'(o_write_enable);
      ob_se[k]  = 32'(o_sense_en);
      ob_pn[k]  = 32'(o_precharge_n);
      ob_rv[k]  = 32'(o_rsp_valid);
      ob_a1[k]  = 32'(o_address_1);
      ob_rd1[k] = o_rsp_rdata1;
      ob_rd2[k] = o_rsp_rdata2;
      if (k < n) @(negedge clk);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 after acceptance.
  task automatic send(input bit [1:0] rd, input bit we, input bit [6:0] ra1,
                      input bit [6:0] ra2, input bit [6:0] wa, input bit [31:0] wd,
                      input bit hold);
    bit got;
    i_req_rd_en  = rd;
    i_req_we     = we;
    i_req_raddr1 = ra1;
    i_req_raddr2 = ra2;
    i_req_waddr  = wa;
    i_req_wdata  = wd;
    i_req_valid  = 1'b1;
    got = 0;
    for (int n = 0; n < 60; n++) begin
      if (o_req_ready === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout: got ready=%b expected 1 within 60 cycles", o_req_ready);
    end
    last_acc = cyc;
    @(posedge clk);
    @(negedge clk);
    if (!hold) i_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int n = 0; n < 60; n++) begin
      if (q.size() == 0 && cur.ready) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL idle_timeout: got queue=%0d expected 0 within 60 cycles", q.size());
    end
  endtask

  // ---------------- Stimulus ----------------
  initial begin
    int r0, a0;
    bit [1:0] rd;
    bit we, hold;
    bit [6:0] ra1, ra2, wa;
    i_req_valid = 0; i_req_rd_en = 0; i_req_we = 0;
    i_req_raddr1 = 0; i_req_raddr2 = 0; i_req_waddr = 0; i_req_wdata = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(o_req_ready), 32'h1);
    chk("rst_precharge_n", 32'(o_precharge_n), 32'h1);
    chk("rst_enables", {28'h0, o_read_enable, o_write_enable, o_sense_en}, 32'h0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'h0);
    chk("rst_addr", {18'h0, o_address_1, o_address_2}, 32'h0);
    chk("rst_bl_wdata", o_bl_wdata, 32'h0);
    chk("rst_rdata", o_rsp_rdata1 | o_rsp_rdata2, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Dual read
    send(2'b11, 0, 7'h3C, 7'h4F, 7'h00, 32'h0, 0);
    observe(4);
    chk("dr_pre_pn", ob_pn[1], 32'h0);
    chk("dr_re_c2", ob_re[2], 32'h3);
    chk("dr_re_c3", ob_re[3], 32'h3);
    chk("dr_se_c2", ob_se[2], 32'h0);
    chk("dr_se_c3", ob_se[3], 32'h1);
    chk("dr_rv_c3", ob_rv[3], 32'h0);
    chk("dr_rv_c4", ob_rv[4], 32'h1);
    chk("dr_rd1", ob_rd1[4], 32'hA5A5_0001);
    chk("dr_rd2", ob_rd2[4], 32'h5A5A_0002);
    wait_idle();

    // Write-only
    send(2'b00, 1, 7'h00, 7'h00, 7'h3C, 32'hDEAD_BEEF, 0);
    observe(4);
    chk("wo_we_c2", ob_we[2], 32'h1);
    chk("wo_we_c3", ob_we[3], 32'h1);
    chk("wo_a1_c2", ob_a1[2], 32'h3C);
    chk("wo_re_c2", ob_re[2], 32'h0);
    chk("wo_rv_c4", ob_rv[4], 32'h1);
    chk("wo_rdata", ob_rd1[4] | ob_rd2[4], 32'h0);
    wait_idle();

    // Read+write, same row: read returns the old data
    send(2'b10, 1, 7'h3C, 7'h00, 7'h3C, 32'h1234_5678, 0);
    observe(7);
    chk("rw_re_c2", ob_re[2], 32'h2);
    chk("rw_prew_pn", ob_pn[4], 32'h0);
    chk("rw_prew_en", ob_re[4] | ob_we[4], 32'h0);
    chk("rw_we_c5", ob_we[5], 32'h1);
    chk("rw_re_c5", ob_re[5], 32'h0);
    chk("rw_rv_c6", ob_rv[6], 32'h0);
    chk("rw_rv_c7", ob_rv[7], 32'h1);
    chk("rw_rd1", ob_rd1[7], 32'hDEAD_BEEF);
    chk("rw_rd2", ob_rd2[7], 32'h0);
    wait_idle();

    // Back-to-back with req_valid held high
    r0 = rsp_cnt;
    send(2'b01, 0, 7'h00, 7'h4F, 7'h00, 32'h0, 1);
    a0 = last_acc;
    send(2'b00, 1, 7'h00, 7'h00, 7'h10, 32'hCAFE_F00D, 0);
    chk("b2b_accept_gap", 32'(last_acc - a0), 32'd5);
    wait_idle();
    chk("b2b_rsp_count", 32'(rsp_cnt - r0), 32'd2);

    // Reset during the first READ cycle
    send(2'b11, 0, 7'h3C, 7'h4F, 7'h00, 32'h0, 0);
    @(negedge clk);
    chk("mr_re_before", 32'(o_read_enable), 32'h3);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_re_after", 32'(o_read_enable), 32'h0);
    chk("mr_pn_after", 32'(o_precharge_n), 32'h1);
    chk("mr_ready_after", 32'(o_req_ready), 32'h1);
    r0 = rsp_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mr_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    send(2'b10, 0, 7'h3C, 7'h00, 7'h00, 32'h0, 0);
    observe(4);
    chk("mr_next_rv", ob_rv[4], 32'h1);
    chk("mr_next_rd1", ob_rd1[4], 32'h1234_5678);
    wait_idle();

    // Randomized traffic; rows biased into a small window to hit same-row cases
    for (int t = 0; t < 60; t++) begin
      rd   = 2'($urandom_range(0, 3));
      we   = 1'($urandom_range(0, 1));
      ra1  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'(7'h38 + $urandom_range(0, 7));
      ra2  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'(7'h38 + $urandom_range(0, 7));
      wa   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'(7'h38 + $urandom_range(0, 7));
      hold = (t != 59) && ($urandom_range(0, 2) == 0);
      send(rd, we, ra1, ra2, wa, $urandom, hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();

    // Array contents must match the model after all writes
    for (int i = 0; i < 128; i++)
      chk($sformatf("mem_%0h", i), arr_rd(7'(i)), model_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
